rx_stream_arbiter: RTL

- Merges N_CH independent UART-receive word streams onto one AXI-stream master port carrying a channel ID.
- Each UART deserializer upstream has only a valid output and cannot be stalled, so this block buffers every channel in a small FIFO.
- Drained FIFOs are scheduled round-robin under downstream backpressure.
- Sits between the per-channel deserializers and the shared packet/DMA logic.

---
 rtl/rx_stream_pkg.sv | 7 +
 rtl/rx_word_fifo.sv | 44 ++++
 rtl/rx_stream_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/rx_stream_pkg.sv
// rx_stream_pkg: shared defaults and word type for the receive-stream arbiter
package rx_stream_pkg;
  localparam int DEF_N_CH = 4;
  localparam int DEF_W_DATA = 16;
  localparam int DEF_DEPTH = 4;
  typedef logic [DEF_W_DATA-1:0] word_t;
endpackage

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: single-clock FIFO buffering one unstallable receive channel
module rx_word_fifo
  import rx_stream_pkg::*;
#(
  parameter int W_DATA = DEF_W_DATA,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [W_DATA-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [W_DATA-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [W_DATA-1:0] mem_q [DEPTH];
  logic wr_en;
  // flags from wrap-bit pointers; a pop frees the slot a same-cycle push needs
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    wr_en = push && (!full || pop);
    wr_d = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d = (pop && !empty) ? rd_q + 1'b1 : rd_q;
    head = mem_q[rd_q[AW-1:0]];
  end
  // pointer registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage array, contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rx_stream_arbiter.sv
// rx_stream_arbiter: merges per-channel receive words onto one AXI-stream port
module rx_stream_arbiter
  import rx_stream_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W_DATA = DEF_W_DATA,
  parameter int DEPTH = DEF_DEPTH,
  parameter int W_ID = $clog2(N_CH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_CH-1:0]              s_valid,
  input  logic [N_CH-1:0][W_DATA-1:0]  s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [W_DATA-1:0]            m_data,
  output logic [W_ID-1:0]              m_id,
  output logic [N_CH-1:0]              overflow,
  input  logic [N_CH-1:0]              clr_overflow
);
  logic [N_CH-1:0] full, empty, pop;
  logic [W_DATA-1:0] head [N_CH];
  logic load_en, found, pop_en;
  logic [W_ID-1:0] grant;
  int j;
  logic m_valid_q, m_valid_d;
  logic [W_DATA-1:0] m_data_q, m_data_d;
  logic [W_ID-1:0] m_id_q, m_id_d, last_q, last_d;
  logic [N_CH-1:0] overflow_q, overflow_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_fifo
    rx_word_fifo #(.W_DATA(W_DATA), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (s_valid[i]),
      .pop   (pop[i]),
      .din   (s_data[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // round-robin search from the channel after the last grant; pop only when the output register loads
  always_comb begin
    load_en = !m_valid_q || m_ready;
    found = 1'b0;
    grant = '0;
    j = 0;
    for (int k = 0; k < N_CH; k++) begin
      j = int'(last_q) + 1 + k;
      if (j >= N_CH) j = j - N_CH;
      if (!found && !empty[j]) begin
        found = 1'b1;
        grant = W_ID'(j);
      end
    end
    pop_en = load_en && found;
    pop = pop_en ? ({{(N_CH-1){1'b0}}, 1'b1} << grant) : '0;
    m_valid_d = load_en ? found : m_valid_q;
    m_data_d = pop_en ? head[grant] : m_data_q;
    m_id_d = pop_en ? grant : m_id_q;
    last_d = pop_en ? grant : last_q;
    overflow_d = (overflow_q & ~clr_overflow) | (s_valid & full & ~pop);
  end

  // output register, round-robin pointer and sticky drop flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_id_q <= '0;
      last_q <= W_ID'(N_CH - 1);
      overflow_q <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_id_q <= m_id_d;
      last_q <= last_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_id = m_id_q;
  assign overflow = overflow_q;
endmodule
